// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states,
// memory latency bounds and the alignment check.
package lsu_ctrl_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_ILL  = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_WAIT   = 2'b10,
        ST_RESP   = 2'b11
    } lsu_state_e;

    localparam int unsigned MEM_LAT_MIN = 1;
    localparam int unsigned MEM_LAT_MAX = 4;

    // Size 11 is never a legal access, so it is reported like a misalignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad_s;
        case (size)
            SIZE_BYTE: bad_s = 1'b0;
            SIZE_HALF: bad_s = addr_lo[0];
            SIZE_WORD: bad_s = (addr_lo != 2'b00);
            default:   bad_s = 1'b1;
        endcase
        return bad_s;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero
// extension for loads; purely combinational.
module lsu_align
    import lsu_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted_s;

    assign shifted_s = rdata >> {addr_lo, 3'b000};

    // Store lane enables and data replication by access size
    always_comb begin
        be         = 4'b0000;
        wdata_lane = 32'h0000_0000;
        case (size)
            SIZE_BYTE: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            SIZE_HALF: begin
                be         = 4'b0011 << addr_lo;
                wdata_lane = {2{wdata[15:0]}};
            end
            SIZE_WORD: begin
                be         = 4'b1111 << addr_lo;
                wdata_lane = wdata;
            end
            default: begin
                be         = 4'b0000;
                wdata_lane = 32'h0000_0000;
            end
        endcase
    end

    // Load data truncation and extension by access size
    always_comb begin
        rdata_ext = 32'h0000_0000;
        case (size)
            SIZE_BYTE: rdata_ext = is_unsigned ? {24'h00_0000, shifted_s[7:0]}
                                               : {{24{shifted_s[7]}}, shifted_s[7:0]};
            SIZE_HALF: rdata_ext = is_unsigned ? {16'h0000, shifted_s[15:0]}
                                               : {{16{shifted_s[15]}}, shifted_s[15:0]};
            SIZE_WORD: rdata_ext = shifted_s;
            default:   rdata_ext = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one request at a time, drives the data
// RAM for MEM_LAT cycles on loads or one cycle on stores, then pulses a response.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_misalign_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic        mem_re_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [1:0] LAT_CNT = 2'(MEM_LAT - 1);

    lsu_state_e  state_r, state_nxt_s;
    logic [1:0]  cnt_r, cnt_nxt_s;
    logic        we_r, uns_r;
    logic [1:0]  size_r;
    logic [31:0] addr_r, wdata_r;

    logic        hs_s, in_mem_s, misalign_nxt_s;
    logic        we_nxt_s, uns_nxt_s;
    logic [1:0]  size_nxt_s;
    logic [31:0] addr_nxt_s, wdata_nxt_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_lane_s, rdata_ext_s;

    logic        ready_r, resp_valid_r, resp_misalign_r, mem_we_r, mem_re_r;
    logic [31:0] resp_rdata_r, mem_addr_r, mem_wdata_r;
    logic [3:0]  mem_be_r;

    assign hs_s        = req_valid_i & ready_r;
    assign we_nxt_s    = hs_s ? req_we_i       : we_r;
    assign uns_nxt_s   = hs_s ? req_unsigned_i : uns_r;
    assign size_nxt_s  = hs_s ? req_size_i     : size_r;
    assign addr_nxt_s  = hs_s ? req_addr_i     : addr_r;
    assign wdata_nxt_s = hs_s ? req_wdata_i    : wdata_r;

    assign misalign_nxt_s = is_misaligned(size_nxt_s, addr_nxt_s[1:0]);

    lsu_align u_align (
        .size        (size_nxt_s),
        .is_unsigned (uns_nxt_s),
        .addr_lo     (addr_nxt_s[1:0]),
        .wdata       (wdata_nxt_s),
        .rdata       (mem_rdata_i),
        .be          (be_s),
        .wdata_lane  (wdata_lane_s),
        .rdata_ext   (rdata_ext_s)
    );

    // Next-state logic and load latency down-counter
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (hs_s) begin
                    if (misalign_nxt_s) begin
                        state_nxt_s = ST_RESP;
                        cnt_nxt_s   = 2'b00;
                    end else begin
                        state_nxt_s = ST_ACCESS;
                        cnt_nxt_s   = req_we_i ? 2'b00 : LAT_CNT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS, ST_WAIT: begin
                if (cnt_r == 2'b00) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = cnt_r - 2'b01;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    assign in_mem_s = (state_nxt_s == ST_ACCESS) || (state_nxt_s == ST_WAIT);

    // State, request fields and registered outputs; outputs reflect the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            cnt_r           <= 2'b00;
            we_r            <= 1'b0;
            uns_r           <= 1'b0;
            size_r          <= 2'b00;
            addr_r          <= 32'h0000_0000;
            wdata_r         <= 32'h0000_0000;
            ready_r         <= 1'b1;
            resp_valid_r    <= 1'b0;
            resp_misalign_r <= 1'b0;
            resp_rdata_r    <= 32'h0000_0000;
            mem_we_r        <= 1'b0;
            mem_re_r        <= 1'b0;
            mem_be_r        <= 4'b0000;
            mem_addr_r      <= 32'h0000_0000;
            mem_wdata_r     <= 32'h0000_0000;
        end else begin
            state_r         <= state_nxt_s;
            cnt_r           <= cnt_nxt_s;
            we_r            <= we_nxt_s;
            uns_r           <= uns_nxt_s;
            size_r          <= size_nxt_s;
            addr_r          <= addr_nxt_s;
            wdata_r         <= wdata_nxt_s;
            ready_r         <= (state_nxt_s == ST_IDLE);
            resp_valid_r    <= (state_nxt_s == ST_RESP);
            resp_misalign_r <= (state_nxt_s == ST_RESP) & misalign_nxt_s;
            // Load data is captured on the last read cycle, as the FSM enters RESP
            resp_rdata_r    <= ((state_nxt_s == ST_RESP) && !we_nxt_s && !misalign_nxt_s)
                               ? rdata_ext_s : 32'h0000_0000;
            mem_we_r        <= in_mem_s & we_nxt_s;
            mem_re_r        <= in_mem_s & ~we_nxt_s;
            mem_be_r        <= in_mem_s ? be_s : 4'b0000;
            mem_addr_r      <= in_mem_s ? {addr_nxt_s[31:2], 2'b00} : 32'h0000_0000;
            mem_wdata_r     <= (in_mem_s & we_nxt_s) ? wdata_lane_s : 32'h0000_0000;
        end
    end

    assign req_ready_o     = ready_r;
    assign resp_valid_o    = resp_valid_r;
    assign resp_misalign_o = resp_misalign_r;
    assign resp_rdata_o    = resp_rdata_r;
    assign mem_we_o        = mem_we_r;
    assign mem_re_o        = mem_re_r;
    assign mem_be_o        = mem_be_r;
    assign mem_addr_o      = mem_addr_r;
    assign mem_wdata_o     = mem_wdata_r;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: one instance with MEM_LAT=1 and one with
// MEM_LAT=3 share the request bus and RAM read data.
module tb_lsu_ctrl;

    logic        clk, rst_n;
    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, mem_rdata, rdata_v;
    logic        use_model;

    logic        d1_ready, d1_resp_valid, d1_resp_misalign, d1_mem_we, d1_mem_re;
    logic [31:0] d1_resp_rdata, d1_mem_addr, d1_mem_wdata;
    logic [3:0]  d1_mem_be;
    logic        d3_ready, d3_resp_valid, d3_resp_misalign, d3_mem_we, d3_mem_re;
    logic [31:0] d3_resp_rdata, d3_mem_addr, d3_mem_wdata;
    logic [3:0]  d3_mem_be;

    int n_checks = 0;
    int n_errors = 0;
    int n_both   = 0;

    lsu_ctrl #(.MEM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(d1_ready),
        .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .resp_valid_o(d1_resp_valid),
        .resp_rdata_o(d1_resp_rdata), .resp_misalign_o(d1_resp_misalign),
        .mem_addr_o(d1_mem_addr), .mem_we_o(d1_mem_we), .mem_re_o(d1_mem_re),
        .mem_be_o(d1_mem_be), .mem_wdata_o(d1_mem_wdata), .mem_rdata_i(mem_rdata)
    );

    lsu_ctrl #(.MEM_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(d3_ready),
        .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .resp_valid_o(d3_resp_valid),
        .resp_rdata_o(d3_resp_rdata), .resp_misalign_o(d3_resp_misalign),
        .mem_addr_o(d3_mem_addr), .mem_we_o(d3_mem_we), .mem_re_o(d3_mem_re),
        .mem_be_o(d3_mem_be), .mem_wdata_o(d3_mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always_comb mem_rdata = use_model ? (32'hA000_0000 | d3_mem_addr) : rdata_v;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    endtask

    // One isolated request; observes both instances for six cycles after the handshake.
    task automatic run_txn(input string tag, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int lat1, input int lat3,
                           input logic [31:0] exp_rdata, input logic exp_mis,
                           input logic [3:0] exp_be, input logic [31:0] exp_mwdata,
                           input logic [31:0] exp_maddr, input int exp_re1, input int exp_re3,
                           input int exp_we);
        int v1_at = 0, v3_at = 0, nv1 = 0, nv3 = 0, re1 = 0, re3 = 0, we1 = 0, we3 = 0;
        int unstable = 0;
        logic [31:0] r1 = 32'h0, r3 = 32'h0, cap_wdata = 32'h0, cap_addr = 32'h0;
        logic m1 = 1'b0, m3 = 1'b0, seen = 1'b0;
        logic [3:0] cap_be = 4'h0;
        @(negedge clk);
        check({tag, "_rdy"}, {31'b0, d1_ready & d3_ready}, 32'd1);
        set_req(we, size, uns, addr, wdata);
        rdata_v = rdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (d1_resp_valid) begin nv1++; if (v1_at == 0) v1_at = k; r1 = d1_resp_rdata; m1 = d1_resp_misalign; end
            if (d3_resp_valid) begin nv3++; if (v3_at == 0) v3_at = k; r3 = d3_resp_rdata; m3 = d3_resp_misalign; end
            if (d1_mem_re) re1++;
            if (d3_mem_re) re3++;
            if (d1_mem_we) we1++;
            if (d3_mem_we) we3++;
            if ((d1_mem_we & d1_mem_re) | (d3_mem_we & d3_mem_re)) n_both++;
            if ((d3_mem_we | d3_mem_re) && !seen) begin
                seen = 1'b1; cap_be = d3_mem_be; cap_wdata = d3_mem_wdata; cap_addr = d3_mem_addr;
            end else if (d3_mem_re && (d3_mem_addr != cap_addr)) begin
                unstable++;
            end
        end
        check({tag, "_lat1"}, v1_at, lat1);
        check({tag, "_lat3"}, v3_at, lat3);
        check({tag, "_nresp1"}, nv1, 32'd1);
        check({tag, "_nresp3"}, nv3, 32'd1);
        check({tag, "_rdata1"}, r1, exp_rdata);
        check({tag, "_rdata3"}, r3, exp_rdata);
        check({tag, "_mis1"}, {31'b0, m1}, {31'b0, exp_mis});
        check({tag, "_mis3"}, {31'b0, m3}, {31'b0, exp_mis});
        check({tag, "_re1"}, re1, exp_re1);
        check({tag, "_re3"}, re3, exp_re3);
        check({tag, "_we1"}, we1, exp_we);
        check({tag, "_we3"}, we3, exp_we);
        if (exp_we != 0 || exp_re3 != 0) begin
            check({tag, "_be"}, {28'b0, cap_be}, {28'b0, exp_be});
            check({tag, "_maddr"}, cap_addr, exp_maddr);
            check({tag, "_stable"}, unstable, 32'd0);
        end
        if (exp_we != 0) check({tag, "_mwdata"}, cap_wdata, exp_mwdata);
    endtask

    logic        b_we[5];
    logic [1:0]  b_size[5];
    logic        b_uns[5];
    logic [31:0] b_addr[5];
    logic [31:0] b_exp[5];
    logic        b_mis[5];
    logic [31:0] got_r[5];
    logic        got_m[5];

    initial begin
        int idx, nresp, viol;
        logic hs;
        rst_n = 1'b0; req_valid = 1'b0; use_model = 1'b0; rdata_v = 32'h0;
        set_req(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, d1_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, d1_resp_valid | d3_resp_valid}, 32'd0);
        check("rst_mem_ctl", {29'b0, d1_mem_we | d3_mem_we, d1_mem_re | d3_mem_re, |d1_mem_be}, 32'd0);
        check("rst_mem_addr", d1_mem_addr | d3_mem_addr, 32'd0);
        rst_n = 1'b1;

        //       tag      we    size   uns   addr          wdata         rdata         l1 l3 exp_rdata     mis   be       mwdata        maddr         re1 re3 we
        run_txn("st_b",   1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_00A5, 32'h0,        2, 2, 32'h0,        1'b0, 4'b1000, 32'hA5A5_A5A5, 32'h0000_0010, 0, 0, 1);
        run_txn("ld_hs",  1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0,        32'h8001_1234, 2, 4, 32'hFFFF_8001, 1'b0, 4'b1100, 32'h0,        32'h0000_0020, 1, 3, 0);
        run_txn("ld_hu",  1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'h0,        32'h8001_1234, 2, 4, 32'h0000_8001, 1'b0, 4'b1100, 32'h0,        32'h0000_0020, 1, 3, 0);
        run_txn("ld_w",   1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0,        32'hDEAD_BEEF, 2, 4, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0,        32'h0000_0040, 1, 3, 0);
        run_txn("st_wmis",1'b1, 2'b10, 1'b0, 32'h0000_0102, 32'h1234_5678, 32'h0,        1, 1, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0,        0, 0, 0);
        run_txn("ld_ill", 1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0,        32'hFFFF_FFFF, 1, 1, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0,        0, 0, 0);
        run_txn("ld_bs",  1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'h0,        32'h0000_8000, 2, 4, 32'hFFFF_FF80, 1'b0, 4'b0010, 32'h0,        32'h0,        1, 3, 0);
        run_txn("st_h",   1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'h1234_ABCD, 32'h0,        2, 2, 32'h0,        1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0,        0, 0, 1);
        run_txn("ld_bu",  1'b0, 2'b00, 1'b1, 32'h0000_0003, 32'h0,        32'hF100_0000, 2, 4, 32'h0000_00F1, 1'b0, 4'b1000, 32'h0,        32'h0,        1, 3, 0);
        run_txn("ld_hmis",1'b0, 2'b01, 1'b0, 32'h0000_0005, 32'h0,        32'h1111_1111, 1, 1, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0,        0, 0, 0);

        // Reset while the MEM_LAT=3 instance is waiting on a load
        @(negedge clk);
        set_req(1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0);
        rdata_v = 32'h1234_5678;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rstw_pre_re", {31'b0, d3_mem_re}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstw_re", {31'b0, d3_mem_re}, 32'd0);
        check("rstw_addr", d3_mem_addr, 32'd0);
        check("rstw_resp", {31'b0, d3_resp_valid}, 32'd0);
        check("rstw_ready", {31'b0, d3_ready}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        set_req(1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'h55AA_55AA);
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rstw_new_we", {31'b0, d3_mem_we}, 32'd1);
        check("rstw_new_addr", d3_mem_addr, 32'h0000_0200);
        check("rstw_no_old_resp", {31'b0, d3_resp_valid}, 32'd0);
        @(negedge clk);
        check("rstw_new_resp", {31'b0, d3_resp_valid}, 32'd1);
        repeat (2) @(negedge clk);

        // Back-to-back requests on the MEM_LAT=3 instance, RAM data = 0xA000_0000 | address
        use_model = 1'b1;
        b_we[0] = 1'b0; b_size[0] = 2'b10; b_uns[0] = 1'b0; b_addr[0] = 32'h04; b_exp[0] = 32'hA000_0004; b_mis[0] = 1'b0;
        b_we[1] = 1'b1; b_size[1] = 2'b10; b_uns[1] = 1'b0; b_addr[1] = 32'h08; b_exp[1] = 32'h0;         b_mis[1] = 1'b0;
        b_we[2] = 1'b0; b_size[2] = 2'b01; b_uns[2] = 1'b0; b_addr[2] = 32'h11; b_exp[2] = 32'h0;         b_mis[2] = 1'b1;
        b_we[3] = 1'b0; b_size[3] = 2'b00; b_uns[3] = 1'b1; b_addr[3] = 32'h0F; b_exp[3] = 32'h0000_00A0; b_mis[3] = 1'b0;
        b_we[4] = 1'b0; b_size[4] = 2'b01; b_uns[4] = 1'b0; b_addr[4] = 32'h1E; b_exp[4] = 32'hFFFF_A000; b_mis[4] = 1'b0;
        idx = 0; nresp = 0; viol = 0;
        @(negedge clk);
        set_req(b_we[0], b_size[0], b_uns[0], b_addr[0], 32'hCAFE_F00D);
        req_valid = 1'b1;
        for (int cyc = 0; cyc < 80 && nresp < 5; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if (d3_resp_valid) begin
                got_r[nresp] = d3_resp_rdata; got_m[nresp] = d3_resp_misalign; nresp++;
            end
            if ((d3_mem_re | d3_mem_we | d3_resp_valid) && d3_ready) viol++;
            if (d3_mem_we & d3_mem_re) n_both++;
            hs = d3_ready & req_valid;
            @(posedge clk);
            #1;
            if (hs) begin
                idx++;
                if (idx < 5) set_req(b_we[idx], b_size[idx], b_uns[idx], b_addr[idx], 32'hCAFE_F00D);
                else req_valid = 1'b0;
            end
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (d3_resp_valid) nresp++;
        end
        check("b2b_nresp", nresp, 32'd5);
        check("b2b_ready_busy", viol, 32'd0);
        for (int i = 0; i < 5 && i < nresp; i++) begin
            check($sformatf("b2b_rdata%0d", i), got_r[i], b_exp[i]);
            check($sformatf("b2b_mis%0d", i), {31'b0, got_m[i]}, {31'b0, b_mis[i]});
        end
        check("we_re_together", n_both, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, giving the read latency in cycles from mem_re_o assertion to valid mem_rdata_i (legal range 1..4).
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid_i  in  1  the execute stage presents a memory request.
REQ-005 SHALL have port req_ready_o  out  1  the block accepts a request this cycle.
REQ-006 SHALL have port req_we_i  in  1  1=store, 0=load.
REQ-007 SHALL have port req_size_i  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned_i  in  1  zero-extend loads when 1, sign-extend when 0.
REQ-009 SHALL have port req_addr_i  in  32  byte address.
REQ-010 SHALL have port req_wdata_i  in  32  store data, right-aligned.
REQ-011 SHALL have port resp_valid_o  out  1  one-cycle completion pulse to writeback.
REQ-012 SHALL have port resp_rdata_o  out  32  extended load data; 0 for stores and faults.
REQ-013 SHALL have port resp_misalign_o  out  1  the completed request was misaligned or illegal.
REQ-014 SHALL have ports mem_addr_o  out  32 (word address, bits[1:0]=0); mem_we_o  out  1; mem_re_o  out  1; mem_be_o  out  4 (byte lane enables); mem_wdata_o  out  32; mem_rdata_i  in  32. These connect to the data RAM.

Function
REQ-015 SHALL implement the FSM states IDLE, ACCESS, WAIT and RESP; req_ready_o is 1 only in IDLE.
REQ-016 SHALL register all request fields on handshake (req_valid_i & req_ready_o) in IDLE; request inputs are ignored in all other states.
REQ-017 SHALL treat a request as misaligned when it is a half access with addr[0]=1, a word access with addr[1:0]!=0, or has size 11; such a request goes IDLE->RESP with no mem_we_o/mem_re_o assertion, then pulses resp_valid_o=1 with resp_misalign_o=1 and resp_rdata_o=0.
REQ-018 SHALL handle a store: ACCESS for one cycle with mem_we_o=1 and mem_be_o = 0001/0011/1111 shifted left by addr[1:0]; mem_wdata_o carries the byte replicated to 4 lanes, the half replicated to 2 lanes, or the word unchanged; resp_valid_o is then asserted in the next cycle.
REQ-019 SHALL handle a load: hold mem_re_o=1 and a stable mem_addr_o for MEM_LAT cycles (ACCESS, then WAIT for MEM_LAT-1 cycles, tracked by a 2-bit down-counter); capture mem_rdata_i on the last cycle and pulse resp_valid_o in the following cycle.
REQ-020 SHALL produce the load result as mem_rdata_i shifted right by 8*addr[1:0], truncated to the access size, and sign- or zero-extended per req_unsigned_i.
REQ-021 SHALL set latency from handshake at cycle T: resp_valid_o at T+2 for stores and for MEM_LAT=1 loads; at T+MEM_LAT+1 for loads; at T+1 for misaligned requests.
REQ-022 SHALL return from RESP to IDLE unconditionally, because writeback always accepts; the next handshake is possible one cycle after resp_valid_o.
REQ-023 SHALL keep mem_we_o, mem_re_o and mem_be_o at 0 outside ACCESS/WAIT, and SHALL never assert mem_we_o and mem_re_o together.

Reset
REQ-024 SHALL asynchronously force on rst_n=0: state IDLE, and every output and internal register 0 except req_ready_o, which is 1 once reset is deasserted.
REQ-025 SHALL drop an in-flight transaction on reset mid-operation without issuing a response; a store whose ACCESS cycle was cut does not count as completed.

Structure
REQ-026 SHALL place the size encodings, the FSM state encodings and the MEM_LAT bounds in the shared buceros_header definitions.
REQ-027 SHALL implement lane steering and extension as one combinational sub-module, lsu_align; the FSM and registers stay in lsu_ctrl.

Verification
REQ-028 SHALL cover: store byte, addr=0x0000_0013, wdata=0x0000_00A5 -> mem_be_o=1000, mem_wdata_o=0xA5A5_A5A5, mem_addr_o=0x10, resp_valid_o at T+2.
REQ-029 SHALL cover: signed load half, addr=0x22, mem_rdata_i=0x8001_1234 -> resp_rdata_o=0xFFFF_8001; the unsigned variant -> 0x0000_8001.
REQ-030 SHALL cover: MEM_LAT=3 word load, addr=0x40 -> mem_re_o high for exactly 3 cycles and resp_valid_o at T+4 carrying mem_rdata_i.
REQ-031 SHALL cover: word store at addr=0x102 -> no mem_we_o, resp_valid_o at T+1 with resp_misalign_o=1; and size=11 -> the same response.
REQ-032 SHALL cover: rst_n pulled low during WAIT -> all outputs immediately 0, no resp_valid_o, and a new request accepted the first cycle after release.
REQ-033 SHALL cover: back-to-back requests with req_valid_i held high -> req_ready_o is low during ACCESS/WAIT/RESP, and every request completes exactly once, in order.
